instr_sequencer: RTL and testbench

//  Fetch/issue front end that drives the control unit. Reads 16-bit instruction words from the ROM port
//  and decodes each into opcode[15:12], dest[11:6], src[5:0]. Presents one instruction at a time and waits
//  for the CU done code (cu_state==2'b11). Then drives opcode 4'b0000 so the CU returns to 2'b00, and advances pc.

---
 rtl/instr_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/issue front end for the control unit. Reads one instruction word from ROM, decodes it
// into opcode/dest/src, presents it to the CU until the CU reports done, then clears the opcode
// so the CU returns to idle and advances the program counter.
module instr_sequencer #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned WDOG_MAX = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [DATA_W-1:0] rom_data_i,
   input  logic [1:0]        cu_state_i,
   output logic [ADDR_W-1:0] rom_address_o,
   output logic              rom_read_enable_o,
   output logic [3:0]        opcode_o,
   output logic [5:0]        dest_o,
   output logic [5:0]        src_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              busy_o,
   output logic              halted_o,
   output logic              illegal_err_o,
   output logic              wdog_err_o,
   output logic [7:0]        retired_o
);

   localparam int unsigned WdogW = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX);

   localparam logic [1:0] CuIdle = 2'b00;
   localparam logic [1:0] CuDone = 2'b11;

   typedef enum logic [2:0] {
      StIdle, StFetch, StWaitRom, StDecode, StIssue, StHold, StRetire, StHalted
   } state_e;

   typedef enum logic [2:0] {
      OpNop, OpHlt, OpIllegal, OpAlu, OpMulti
   } op_class_e;

   state_e            state_q;
   op_class_e         op_class;
   logic [3:0]        rom_op;
   logic [5:0]        rom_dest;
   logic [5:0]        rom_src;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] rom_address_q;
   logic              rom_read_enable_q;
   logic [3:0]        opcode_q;
   logic [5:0]        dest_q;
   logic [5:0]        src_q;
   logic              busy_q;
   logic              halted_q;
   logic              illegal_err_q;
   logic              wdog_err_q;
   logic [7:0]        retired_q;
   logic [WdogW-1:0]  wdog_cnt_q;

   assign rom_op   = rom_data_i[15:12];
   assign rom_dest = rom_data_i[11:6];
   assign rom_src  = rom_data_i[5:0];
   assign pc_inc   = pc_q + ADDR_W'(1);

   // Classify the word currently on the ROM port (sampled only in DECODE)
   always_comb begin
      op_class = OpAlu;
      unique case (rom_op)
         4'h0:                   op_class = OpNop;
         4'hF:                   op_class = OpHlt;
         4'hD, 4'hE:             op_class = OpIllegal;
         4'h1, 4'h2, 4'h3, 4'hC: op_class = OpMulti;
         default:                op_class = OpAlu;
      endcase
   end

   // Sequencer FSM; every output is a register so the CU sees glitch-free controls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= StIdle;
         pc_q              <= '0;
         rom_address_q     <= '0;
         rom_read_enable_q <= 1'b0;
         opcode_q          <= 4'h0;
         dest_q            <= 6'h0;
         src_q             <= 6'h0;
         busy_q            <= 1'b0;
         halted_q          <= 1'b0;
         illegal_err_q     <= 1'b0;
         wdog_err_q        <= 1'b0;
         retired_q         <= 8'h0;
         wdog_cnt_q        <= '0;
      end else begin
         // Read strobe is a single-cycle pulse, raised only on entry to FETCH
         rom_read_enable_q <= 1'b0;
         case (state_q)
            StIdle, StHalted: begin
               if (start_i) begin
                  state_q           <= StFetch;
                  pc_q              <= '0;
                  rom_address_q     <= '0;
                  rom_read_enable_q <= 1'b1;
                  busy_q            <= 1'b1;
                  halted_q          <= 1'b0;
                  illegal_err_q     <= 1'b0;
                  wdog_err_q        <= 1'b0;
               end
            end
            StFetch:   state_q <= StWaitRom;
            StWaitRom: state_q <= StDecode;
            StDecode: begin
               unique case (op_class)
                  OpNop: state_q <= StRetire;
                  OpHlt: begin
                     // pc stays on the HLT so software can see where execution stopped
                     retired_q <= retired_q + 8'd1;
                     halted_q  <= 1'b1;
                     busy_q    <= 1'b0;
                     state_q   <= StHalted;
                  end
                  OpIllegal: begin
                     illegal_err_q <= 1'b1;
                     state_q       <= StRetire;
                  end
                  OpAlu: begin
                     // Single-cycle op: HOLD provides the one cycle of drive
                     opcode_q <= rom_op;
                     dest_q   <= rom_dest;
                     src_q    <= rom_src;
                     state_q  <= StHold;
                  end
                  default: begin
                     opcode_q   <= rom_op;
                     dest_q     <= rom_dest;
                     src_q      <= rom_src;
                     wdog_cnt_q <= '0;
                     state_q    <= StIssue;
                  end
               endcase
            end
            StIssue: begin
               if (cu_state_i == CuDone) begin
                  state_q <= StHold;
               end else if (wdog_cnt_q == WdogW'(WDOG_MAX - 1)) begin
                  wdog_err_q <= 1'b1;
                  opcode_q   <= 4'h0;
                  dest_q     <= 6'h0;
                  src_q      <= 6'h0;
                  state_q    <= StRetire;
               end else begin
                  wdog_cnt_q <= wdog_cnt_q + WdogW'(1);
               end
            end
            StHold: begin
               // Extra cycle lets ADD/SUB commit their RAM write before the opcode drops
               opcode_q <= 4'h0;
               dest_q   <= 6'h0;
               src_q    <= 6'h0;
               state_q  <= StRetire;
            end
            StRetire: begin
               if (cu_state_i == CuIdle) begin
                  retired_q         <= retired_q + 8'd1;
                  pc_q              <= pc_inc;
                  rom_address_q     <= pc_inc;
                  rom_read_enable_q <= 1'b1;
                  state_q           <= StFetch;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rom_address_o     = rom_address_q;
   assign rom_read_enable_o = rom_read_enable_q;
   assign opcode_o          = opcode_q;
   assign dest_o            = dest_q;
   assign src_o             = src_q;
   assign pc_o              = pc_q;
   assign busy_o            = busy_q;
   assign halted_o          = halted_q;
   assign illegal_err_o     = illegal_err_q;
   assign wdog_err_o        = wdog_err_q;
   assign retired_o         = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a synchronous ROM and a small behavioural CU/RAM model.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [15:0] rom_data_i;
   logic [1:0]  cu_state_i;
   logic [7:0]  rom_address_o;
   logic        rom_read_enable_o;
   logic [3:0]  opcode_o;
   logic [5:0]  dest_o;
   logic [5:0]  src_o;
   logic [7:0]  pc_o;
   logic        busy_o;
   logic        halted_o;
   logic        illegal_err_o;
   logic        wdog_err_o;
   logic [7:0]  retired_o;

   int npass   = 0;
   int nchecks = 0;

   logic [15:0] rom [256];
   logic [15:0] ram [64];
   logic [15:0] rom_q;
   logic [1:0]  cu_q;
   logic        cu_force;

   int op1_cycles  = 0;
   int opd_cycles  = 0;
   int nz_cycles   = 0;
   int stray_field = 0;

   always #5 clk = ~clk;

   instr_sequencer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start_i           (start_i),
      .rom_data_i        (rom_data_i),
      .cu_state_i        (cu_state_i),
      .rom_address_o     (rom_address_o),
      .rom_read_enable_o (rom_read_enable_o),
      .opcode_o          (opcode_o),
      .dest_o            (dest_o),
      .src_o             (src_o),
      .pc_o              (pc_o),
      .busy_o            (busy_o),
      .halted_o          (halted_o),
      .illegal_err_o     (illegal_err_o),
      .wdog_err_o        (wdog_err_o),
      .retired_o         (retired_o)
   );

   // Synchronous ROM: data appears the cycle after the read strobe and is held
   always @(posedge clk) begin
      if (rom_read_enable_o) rom_q <= rom[rom_address_o];
   end
   assign rom_data_i = rom_q;

   // CU model: 00 -> 01 -> 11 while an opcode is presented; commits on reaching done
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cu_q <= 2'b00;
      end else if (opcode_o == 4'h0) begin
         cu_q <= 2'b00;
      end else begin
         case (cu_q)
            2'b00: cu_q <= 2'b01;
            2'b01: begin
               cu_q <= 2'b11;
               case (opcode_o)
                  4'h1: ram[dest_o] <= ram[src_o];
                  4'h2: ram[dest_o] <= ram[dest_o] + ram[src_o];
                  4'h3: ram[dest_o] <= ram[dest_o] - ram[src_o];
                  4'hC: ram[dest_o] <= {10'h0, src_o};
                  default: ;
               endcase
            end
            default: cu_q <= 2'b11;
         endcase
      end
   end
   assign cu_state_i = cu_force ? 2'b00 : cu_q;

   // Observe what the CU is shown each cycle
   always @(negedge clk) begin
      if (opcode_o == 4'h1) op1_cycles <= op1_cycles + 1;
      if (opcode_o == 4'hD) opd_cycles <= opd_cycles + 1;
      if (opcode_o != 4'h0) nz_cycles <= nz_cycles + 1;
      if (opcode_o == 4'h0 && (dest_o != 6'h0 || src_o != 6'h0)) stray_field <= stray_field + 1;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not reach its summary");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      cu_force = 1'b0;
      start_i  = 1'b0;
      rst_n    = 1'b0;
      #2;
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
   endtask

   task automatic run_to_halt(input string tag);
      int n = 0;
      while (!halted_o && n < 2000) begin
         tick(1);
         n++;
      end
      check({tag, "_halted"}, 32'(halted_o), 32'd1);
   endtask

   initial begin
      int base_a;
      int base_b;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      cu_force = 1'b0;
      start_i  = 1'b0;
      rst_n    = 1'b0;
      #3;

      // Reset state while held in reset
      check("rst_opcode", 32'(opcode_o), 32'h0);
      check("rst_pc", 32'(pc_o), 32'h0);
      check("rst_romaddr", 32'(rom_address_o), 32'h0);
      check("rst_ren", 32'(rom_read_enable_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);
      check("rst_halted", 32'(halted_o), 32'h0);
      check("rst_errs", {30'h0, illegal_err_o, wdog_err_o}, 32'h0);
      check("rst_retired", 32'(retired_o), 32'h0);
      check("rst_fields", {20'h0, dest_o, src_o}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(2);

      // MVI r0,#5 ; MVI r1,#3 ; ADD r0,r1 ; HLT
      rom[0] = 16'hC005;
      rom[1] = 16'hC043;
      rom[2] = 16'h2001;
      rom[3] = 16'hF000;
      pulse_start();
      check("lat_ren", 32'(rom_read_enable_o), 32'd1);
      check("lat_addr", 32'(rom_address_o), 32'h0);
      check("lat_busy", 32'(busy_o), 32'd1);
      tick(1);
      check("ren_pulse", 32'(rom_read_enable_o), 32'd0);
      run_to_halt("prog");
      check("prog_ram0", 32'(ram[0]), 32'd8);
      check("prog_ram1", 32'(ram[1]), 32'd3);
      check("prog_retired", 32'(retired_o), 32'd4);
      check("prog_pc", 32'(pc_o), 32'd3);
      check("prog_busy", 32'(busy_o), 32'd0);

      // NOP ; NOP ; HLT: nothing reaches the CU
      apply_reset();
      rom[0] = 16'h0000;
      rom[1] = 16'h0000;
      rom[2] = 16'hF000;
      base_a = nz_cycles;
      pulse_start();
      run_to_halt("nop");
      check("nop_no_issue", 32'(nz_cycles - base_a), 32'd0);
      check("nop_retired", 32'(retired_o), 32'd3);
      check("nop_pc", 32'(pc_o), 32'd2);

      // Illegal opcode is flagged, retired and never shown to the CU
      apply_reset();
      rom[0] = 16'hD000;
      rom[1] = 16'hF000;
      base_b = opd_cycles;
      pulse_start();
      run_to_halt("ill");
      check("ill_err", 32'(illegal_err_o), 32'd1);
      check("ill_retired", 32'(retired_o), 32'd2);
      check("ill_not_issued", 32'(opd_cycles - base_b), 32'd0);
      // Restart from HALTED clears sticky errors
      rom[0] = 16'hF000;
      pulse_start();
      check("restart_err_clr", 32'(illegal_err_o), 32'd0);
      check("restart_halt_clr", 32'(halted_o), 32'd0);
      run_to_halt("restart");
      check("restart_retired", 32'(retired_o), 32'd3);
      check("restart_pc", 32'(pc_o), 32'd0);

      // Watchdog: CU never reports done
      apply_reset();
      cu_force = 1'b1;
      rom[0] = 16'h1001;
      rom[1] = 16'hF000;
      base_a = op1_cycles;
      pulse_start();
      run_to_halt("wdog");
      check("wdog_issue_cycles", 32'(op1_cycles - base_a), 32'd15);
      check("wdog_err", 32'(wdog_err_o), 32'd1);
      check("wdog_pc", 32'(pc_o), 32'd1);
      check("wdog_retired", 32'(retired_o), 32'd2);
      check("wdog_no_illegal", 32'(illegal_err_o), 32'd0);

      // Asynchronous reset while ADD is in ISSUE at pc=1
      apply_reset();
      cu_force = 1'b1;
      rom[0] = 16'h0000;
      rom[1] = 16'h2001;
      pulse_start();
      tick(8);
      check("mid_opcode", 32'(opcode_o), 32'h2);
      check("mid_src", 32'(src_o), 32'h1);
      check("mid_pc", 32'(pc_o), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_opcode", 32'(opcode_o), 32'h0);
      check("async_busy", 32'(busy_o), 32'h0);
      check("async_pc", 32'(pc_o), 32'h0);
      check("async_retired", 32'(retired_o), 32'h0);

      // 256 NOPs: pc and retired wrap, start mid-run ignored
      apply_reset();
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      pulse_start();
      tick(40);
      pulse_start();
      tick(4 * 255 - 41);
      check("wrap_pc255", 32'(pc_o), 32'd255);
      check("wrap_ret255", 32'(retired_o), 32'd255);
      tick(4);
      check("wrap_pc0", 32'(pc_o), 32'd0);
      check("wrap_ret0", 32'(retired_o), 32'd0);
      check("wrap_busy", 32'(busy_o), 32'd1);
      check("wrap_halted", 32'(halted_o), 32'd0);

      check("fields_zero_when_idle", 32'(stray_field), 32'd0);

      $display("%0d/%0d checks passed", npass, nchecks);
      $finish;
   end

endmodule
